// File: rtl/motor_ramp_scheduler_pkg.sv
// Shared duty width, duty ceiling, channel state encodings and helpers for the
// motor ramp scheduler.
`ifndef DUTY_CYCLE_SIZE
`define DUTY_CYCLE_SIZE 10
`endif
`ifndef MAX_DC
`define MAX_DC 1000
`endif
`ifndef ST_OFF
`define ST_OFF 2'd0
`endif
`ifndef ST_RAMP
`define ST_RAMP 2'd1
`endif
`ifndef ST_RUN
`define ST_RUN 2'd2
`endif
`ifndef ST_BRAKE
`define ST_BRAKE 2'd3
`endif

package motor_ramp_scheduler_pkg;

    localparam int unsigned DUTY_W   = `DUTY_CYCLE_SIZE;
    localparam int unsigned MAX_DUTY = `MAX_DC;

    typedef enum logic [1:0] {
        CH_OFF   = `ST_OFF,
        CH_RAMP  = `ST_RAMP,
        CH_RUN   = `ST_RUN,
        CH_BRAKE = `ST_BRAKE
    } ch_state_e;

    // Direction and duty pair, used for per-channel targets
    typedef struct packed {
        logic              dir;
        logic [DUTY_W-1:0] duty;
    } ch_set_t;

    // Limit a requested duty to the ceiling
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_W'(MAX_DUTY)) ? DUTY_W'(MAX_DUTY) : d;
    endfunction

endpackage

// File: rtl/motor_ramp_scheduler_ramp_tick_gen.sv
// Ramp sweep timer: a free-running tick counter that launches one sweep of
// consecutive channel slots every PERIOD cycles.
module ramp_tick_gen #(
    parameter int unsigned NUM_SLOTS = 6,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned PERIOD    = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             slot_valid,
    output logic [IDX_W-1:0] slot_idx
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] tick;
    logic             wrap_c;

    assign wrap_c = (tick == CNT_W'(PERIOD - 1));

    // Tick counter 0..PERIOD-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick <= '0;
        end else if (wrap_c) begin
            tick <= '0;
        end else begin
            tick <= tick + CNT_W'(1);
        end
    end

    // Slot sequencer: slots 0..NUM_SLOTS-1 on the cycles following a wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= 1'b0;
            slot_idx   <= '0;
        end else if (wrap_c) begin
            slot_valid <= 1'b1;
            slot_idx   <= '0;
        end else if (slot_valid) begin
            if (slot_idx == IDX_W'(NUM_SLOTS - 1)) begin
                slot_valid <= 1'b0;
            end else begin
                slot_idx <= slot_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/motor_ramp_scheduler.sv
// Multi-channel motor ramp scheduler: slew-limits each channel's duty toward
// its commanded target and brakes to zero before any direction reversal.
// Optional command watchdog: define MOTOR_RAMP_WATCHDOG_EN.
module motor_ramp_scheduler
    import motor_ramp_scheduler_pkg::*;
#(
    parameter int unsigned NUM_MOTORS      = 6,
    parameter int unsigned MOTOR_IDX_W     = 3,
    parameter int unsigned RAMP_PERIOD     = 50000,
    parameter int unsigned RAMP_STEP       = 8,
    parameter int unsigned WATCHDOG_CYCLES = 5000000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [MOTOR_IDX_W-1:0]       cmd_motor,
    input  logic                         cmd_dir,
    input  logic                         cmd_on,
    input  logic [DUTY_W-1:0]            cmd_duty,
    output logic                         cmd_err,
    input  logic                         estop,
    output logic [NUM_MOTORS-1:0]        dir_out,
    output logic [NUM_MOTORS-1:0]        on_out,
    output logic [NUM_MOTORS*DUTY_W-1:0] duty_out,
    output logic [NUM_MOTORS-1:0]        busy
);

    localparam int unsigned DW     = DUTY_W;
    localparam int unsigned SW     = DUTY_W + 1;
    localparam int unsigned CMP_W  = MOTOR_IDX_W + 1;

    // Reject configurations the sweep cannot serve
    if (NUM_MOTORS < 1 || NUM_MOTORS > 8 || RAMP_PERIOD < NUM_MOTORS + 1 ||
        WATCHDOG_CYCLES < 1) begin : g_cfg_check
        $error("motor_ramp_scheduler: unsupported parameter set");
    end

    logic                   slot_valid;
    logic [MOTOR_IDX_W-1:0] slot_idx;
    logic                   cmd_fire;
    logic                   wd_trip;

    ch_state_e              st_q       [NUM_MOTORS];
    ch_state_e              st_d       [NUM_MOTORS];
    logic [DW-1:0]          cur_duty_q [NUM_MOTORS];
    logic [DW-1:0]          cur_duty_d [NUM_MOTORS];
    logic                   cur_dir_q  [NUM_MOTORS];
    logic                   cur_dir_d  [NUM_MOTORS];
    ch_set_t                tgt_q      [NUM_MOTORS];
    ch_set_t                tgt_d      [NUM_MOTORS];

    assign cmd_fire = cmd_valid && cmd_ready;

    // One step up toward tgt, never past it
    function automatic logic [DW-1:0] step_up(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] tgt);
        logic [SW-1:0] sum;
        sum = {1'b0, cur} + SW'(RAMP_STEP);
        return (sum >= {1'b0, tgt}) ? tgt : sum[DW-1:0];
    endfunction

    // One step down toward tgt, never below it (and never below zero)
    function automatic logic [DW-1:0] step_down(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] tgt);
        logic [SW-1:0] diff;
        diff = {1'b0, cur} - SW'(RAMP_STEP);
        return (diff[DW] || (diff <= {1'b0, tgt})) ? tgt : diff[DW-1:0];
    endfunction

    ramp_tick_gen #(
        .NUM_SLOTS (NUM_MOTORS),
        .IDX_W     (MOTOR_IDX_W),
        .PERIOD    (RAMP_PERIOD)
    ) u_tick_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .slot_valid (slot_valid),
        .slot_idx   (slot_idx)
    );

`ifdef MOTOR_RAMP_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Command-silence counter; saturates once the limit is reached
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (cmd_fire) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_W'(WATCHDOG_CYCLES)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_trip = !cmd_fire && (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));
`else
    assign wd_trip = 1'b0;
`endif

    // Channel state, target and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                st_q[i]       <= CH_OFF;
                cur_duty_q[i] <= '0;
                cur_dir_q[i]  <= 1'b0;
                tgt_q[i]      <= '0;
            end
            on_out    <= '0;
            busy      <= '0;
            cmd_ready <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                st_q[i]       <= st_d[i];
                cur_duty_q[i] <= cur_duty_d[i];
                cur_dir_q[i]  <= cur_dir_d[i];
                tgt_q[i]      <= tgt_d[i];
                on_out[i]     <= (cur_duty_d[i] != '0);
                busy[i]       <= (st_d[i] == CH_RAMP) || (st_d[i] == CH_BRAKE);
            end
            cmd_ready <= !estop;
            cmd_err   <= cmd_fire && ({1'b0, cmd_motor} >= CMP_W'(NUM_MOTORS));
        end
    end

    // Next-state: estop override, slot ramp rules on old target, then target updates
    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            st_d[i]       = st_q[i];
            cur_duty_d[i] = cur_duty_q[i];
            cur_dir_d[i]  = cur_dir_q[i];
            tgt_d[i]      = tgt_q[i];
        end

        if (estop) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                st_d[i]       = CH_OFF;
                cur_duty_d[i] = '0;
                tgt_d[i].duty = '0;
            end
        end else begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (slot_valid && (slot_idx == MOTOR_IDX_W'(i))) begin
                    if ((tgt_q[i].duty == '0) || (tgt_q[i].dir != cur_dir_q[i])) begin
                        if (cur_duty_q[i] != '0) begin
                            cur_duty_d[i] = step_down(cur_duty_q[i], '0);
                            st_d[i]       = CH_BRAKE;
                        end else begin
                            cur_dir_d[i] = tgt_q[i].dir;
                            st_d[i]      = (tgt_q[i].duty == '0) ? CH_OFF : CH_RAMP;
                        end
                    end else begin
                        if (cur_duty_q[i] < tgt_q[i].duty) begin
                            cur_duty_d[i] = step_up(cur_duty_q[i], tgt_q[i].duty);
                        end else if (cur_duty_q[i] > tgt_q[i].duty) begin
                            cur_duty_d[i] = step_down(cur_duty_q[i], tgt_q[i].duty);
                        end
                        st_d[i] = (cur_duty_d[i] == tgt_q[i].duty) ? CH_RUN : CH_RAMP;
                    end
                end
            end

            if (wd_trip) begin
                for (int i = 0; i < NUM_MOTORS; i++) begin
                    tgt_d[i].duty = '0;
                end
            end

            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (cmd_fire && (cmd_motor == MOTOR_IDX_W'(i))) begin
                    tgt_d[i].dir  = cmd_dir;
                    tgt_d[i].duty = cmd_on ? clamp_duty(cmd_duty) : '0;
                end
            end
        end
    end

    // Pack per-channel direction and duty onto the output buses
    always_comb begin
        dir_out  = '0;
        duty_out = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            dir_out[i]            = cur_dir_q[i];
            duty_out[i*DW +: DW]  = cur_duty_q[i];
        end
    end

endmodule

// File: tb/tb_motor_ramp_scheduler.sv
// Directed bench for motor_ramp_scheduler with a short sweep period.
module tb_motor_ramp_scheduler;
    import motor_ramp_scheduler_pkg::*;

    localparam int unsigned NM   = 4;
    localparam int unsigned IW   = 3;
    localparam int unsigned PER  = 8;
    localparam int unsigned STEP = 8;
    localparam int unsigned WD   = 100;
    localparam int unsigned DW   = DUTY_W;

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IW-1:0]     cmd_motor;
    logic              cmd_dir;
    logic              cmd_on;
    logic [DW-1:0]     cmd_duty;
    logic              cmd_err;
    logic              estop;
    logic [NM-1:0]     dir_out;
    logic [NM-1:0]     on_out;
    logic [NM*DW-1:0]  duty_out;
    logic [NM-1:0]     busy;

    int cyc;
    int n_chk;
    int n_fail;

    motor_ramp_scheduler #(
        .NUM_MOTORS      (NM),
        .MOTOR_IDX_W     (IW),
        .RAMP_PERIOD     (PER),
        .RAMP_STEP       (STEP),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_motor (cmd_motor),
        .cmd_dir   (cmd_dir),
        .cmd_on    (cmd_on),
        .cmd_duty  (cmd_duty),
        .cmd_err   (cmd_err),
        .estop     (estop),
        .dir_out   (dir_out),
        .on_out    (on_out),
        .duty_out  (duty_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release; sweep m starts at edge m*PER
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] duty_of(input int ch);
        return duty_out[ch*DW +: DW];
    endfunction

    task automatic check_ch(input string tag, input int ch, input int e_duty,
                            input logic e_dir, input logic e_busy);
        chk_eq({tag, ".duty"}, 64'(duty_of(ch)), 64'(e_duty));
        chk_eq({tag, ".on"},   64'(on_out[ch]),  64'(e_duty != 0));
        chk_eq({tag, ".dir"},  64'(dir_out[ch]), 64'(e_dir));
        chk_eq({tag, ".busy"}, 64'(busy[ch]),    64'(e_busy));
    endtask

    // Called #1 after an edge; command accepted on the following edge
    task automatic send_cmd(input logic [IW-1:0] m, input logic d, input logic on,
                            input logic [DW-1:0] duty);
        cmd_valid = 1'b1;
        cmd_motor = m;
        cmd_dir   = d;
        cmd_on    = on;
        cmd_duty  = duty;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Advance to #1 after the first completed sweep that lies ahead
    task automatic next_sweep();
        int goal;
        goal = (cyc / PER) * PER + NM + 1;
        if (goal <= cyc || goal < PER) goal += PER;
        while (cyc < goal) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        clk       = 1'b0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_motor = '0;
        cmd_dir   = 1'b0;
        cmd_on    = 1'b0;
        cmd_duty  = '0;
        estop     = 1'b0;
        n_chk     = 0;
        n_fail    = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst.cmd_ready", 64'(cmd_ready), 64'(0));
        chk_eq("rst.on_out",    64'(on_out),    64'(0));
        chk_eq("rst.duty_out",  64'(duty_out),  64'(0));
        chk_eq("rst.dir_out",   64'(dir_out),   64'(0));
        chk_eq("rst.busy",      64'(busy),      64'(0));
        chk_eq("rst.cmd_err",   64'(cmd_err),   64'(0));
        reset_n = 1'b1;
        #1;
        chk_eq("rel.cmd_ready_pre", 64'(cmd_ready), 64'(0));
        @(posedge clk);
        #1;
        chk_eq("rel.cmd_ready", 64'(cmd_ready), 64'(1));

        // Ramp-up: first sweep only flips direction, then 8, 16, 20
        send_cmd(3'd1, 1'b1, 1'b1, 10'd20);
        next_sweep(); check_ch("up0", 1, 0,  1'b1, 1'b1);
        next_sweep(); check_ch("up1", 1, 8,  1'b1, 1'b1);
        next_sweep(); check_ch("up2", 1, 16, 1'b1, 1'b1);
        next_sweep(); check_ch("up3", 1, 20, 1'b1, 1'b0);
        next_sweep(); check_ch("up4", 1, 20, 1'b1, 1'b0);

        // Reversal: brake to zero on old direction, flip at zero, ramp up
        send_cmd(3'd1, 1'b0, 1'b1, 10'd16);
        next_sweep(); check_ch("rev0", 1, 12, 1'b1, 1'b1);
        next_sweep(); check_ch("rev1", 1, 4,  1'b1, 1'b1);
        next_sweep(); check_ch("rev2", 1, 0,  1'b1, 1'b1);
        next_sweep(); check_ch("rev3", 1, 0,  1'b0, 1'b1);
        next_sweep(); check_ch("rev4", 1, 8,  1'b0, 1'b1);
        next_sweep(); check_ch("rev5", 1, 16, 1'b0, 1'b0);

        // Clamp: duty 1023 stops at the ceiling (refreshed to keep targets alive)
        for (int k = 0; k < 130; k++) begin
            send_cmd(3'd2, 1'b1, 1'b1, 10'd1023);
            next_sweep();
        end
        check_ch("clamp.ch2", 2, int'(MAX_DUTY), 1'b1, 1'b0);
        check_ch("clamp.ch1", 1, 16, 1'b0, 1'b0);

        // Invalid channel: one-cycle error pulse, nothing changes
        send_cmd(3'd5, 1'b1, 1'b1, 10'd100);
        chk_eq("inv.err_hi", 64'(cmd_err), 64'(1));
        @(posedge clk);
        #1;
        chk_eq("inv.err_lo", 64'(cmd_err), 64'(0));
        next_sweep();
        next_sweep();
        chk_eq("inv.duty_vec", 64'(duty_out),
               64'({DW'(0), DW'(MAX_DUTY), DW'(16), DW'(0)}));
        chk_eq("inv.dir_vec", 64'(dir_out), 64'(4'b0100));
        chk_eq("inv.on_vec",  64'(on_out),  64'(4'b0110));

        // Emergency stop during a ramp
        send_cmd(3'd3, 1'b0, 1'b1, 10'd40);
        next_sweep(); check_ch("es.pre0", 3, 8,  1'b0, 1'b1);
        next_sweep(); check_ch("es.pre1", 3, 16, 1'b0, 1'b1);
        estop = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("es.on_out",    64'(on_out),    64'(0));
        chk_eq("es.duty_out",  64'(duty_out),  64'(0));
        chk_eq("es.busy",      64'(busy),      64'(0));
        chk_eq("es.cmd_ready", 64'(cmd_ready), 64'(0));
        chk_eq("es.dir_hold",  64'(dir_out),   64'(4'b0100));
        repeat (2) @(posedge clk);
        #1;
        estop = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("es.ready_back", 64'(cmd_ready), 64'(1));
        next_sweep();
        chk_eq("es.stay_off", 64'(duty_out), 64'(0));
        check_ch("es.ch3_off", 3, 0, 1'b0, 1'b0);
        send_cmd(3'd3, 1'b0, 1'b1, 10'd24);
        next_sweep(); check_ch("es.up0", 3, 8,  1'b0, 1'b1);
        next_sweep(); check_ch("es.up1", 3, 16, 1'b0, 1'b1);
        next_sweep(); check_ch("es.up2", 3, 24, 1'b0, 1'b0);

        // Back-to-back commands: the later one wins
        send_cmd(3'd0, 1'b0, 1'b1, 10'd100);
        send_cmd(3'd0, 1'b0, 1'b1, 10'd16);
        acc = cyc;
        next_sweep(); check_ch("b2b0", 0, 8,  1'b0, 1'b1);
        next_sweep(); check_ch("b2b1", 0, 16, 1'b0, 1'b0);

        // Command silence: watchdog ramps targets to zero only when built in
        while (cyc < acc + int'(WD) + 4 * int'(PER)) next_sweep();
`ifdef MOTOR_RAMP_WATCHDOG_EN
        chk_eq("wd.ch0_duty", 64'(duty_of(0)), 64'(0));
        chk_eq("wd.ch0_on",   64'(on_out[0]),  64'(0));
        chk_eq("wd.ch3_duty", 64'(duty_of(3)), 64'(0));
`else
        chk_eq("wd.ch0_duty", 64'(duty_of(0)), 64'(16));
        chk_eq("wd.ch0_on",   64'(on_out[0]),  64'(1));
        chk_eq("wd.ch3_duty", 64'(duty_of(3)), 64'(24));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_ramp_scheduler.md
# motor_ramp_scheduler

Multi-channel sequencer that sits between the command interface and the array of H-bridge motor controllers. It accepts per-motor target commands (direction, on, duty), slew-limits each channel's duty toward its target, and forces a ramp-down to zero before any direction reversal. A single shared ramp step unit is time-multiplexed across channels by a periodic round-robin sweep. An emergency stop input zeroes all channels immediately.

## Interface
- NUM_MOTORS, 6, number of channels (1..8)
- MOTOR_IDX_W, 3, width of the motor index field
- RAMP_PERIOD, 50000, clk cycles between sweep starts (≥ NUM_MOTORS + 1)
- RAMP_STEP, 8, duty units added or removed per channel per sweep
- WATCHDOG_CYCLES, 5000000, command-silence limit (used only with the watchdog feature)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_motor  in  MOTOR_IDX_W  target channel
- cmd_dir  in  1  requested direction
- cmd_on  in  1  requested enable
- cmd_duty  in  `DUTY_CYCLE_SIZE  requested duty
- cmd_err  out  1  one-cycle pulse: command with cmd_motor ≥ NUM_MOTORS was dropped
- estop  in  1  synchronous level emergency stop
- dir_out  out  NUM_MOTORS  per-channel dir to motor controllers
- on_out  out  NUM_MOTORS  per-channel on
- duty_out  out  NUM_MOTORS*`DUTY_CYCLE_SIZE  packed duties; channel i occupies bits [i*DW +: DW]
- busy  out  NUM_MOTORS  channel in RAMP or BRAKE

## Operation
- Per channel: target {tgt_dir, tgt_duty}, current {cur_dir, cur_duty}, state ∈ {OFF, RAMP, RUN, BRAKE}.
- Accepted command: tgt_dir ← cmd_dir; tgt_duty ← cmd_on ? min(cmd_duty, `MAX_DC) : 0.
- Sweep: a tick counter counts 0..RAMP_PERIOD-1. At wrap, slots 0..NUM_MOTORS-1 run on consecutive cycles, one channel per slot. Each slot applies these rules in order:
  - tgt_duty == 0 or tgt_dir ≠ cur_dir, with cur_duty > 0: cur_duty ← sat0(cur_duty − RAMP_STEP); state BRAKE.
  - Same condition, with cur_duty == 0: cur_dir ← tgt_dir; state ← OFF if tgt_duty == 0, else RAMP.
  - Otherwise: move cur_duty toward tgt_duty by RAMP_STEP, saturating exactly at tgt_duty. State is RUN when equal, else RAMP.
- Direction changes only in a slot where cur_duty == 0. A reversal therefore always passes through at least one slot with on_out = 0.
- Arithmetic uses DW+1 bits internally. Results never underflow below 0 and never overshoot the target.
- Outputs are registered: on_out[i] = (cur_duty ≠ 0), dir_out[i] = cur_dir, duty_out[i] = cur_duty.
- cmd_ready:
  - Low during reset and while estop is high.
  - High otherwise.
- estop high:
  - All cur_duty and tgt_duty cleared, states forced to OFF, cur_dir and tgt_dir held.
  - Tick counter continues to run.

## Timing
- Reset values:
  - All outputs 0, cmd_ready 0.
  - All state OFF, tick counter 0.
  - cmd_ready rises on the first clk edge after reset_n deasserts.
- Target registers update on the accepting edge. The new target takes effect at that channel's next slot.
- A command landing in the same cycle as that channel's slot: the slot uses the old target, and the new target applies on the next sweep.
- Outputs change on the edge ending the channel's slot.
- cmd_err asserts the cycle after an invalid command is accepted.
- estop: on_out and duty_out read 0 on the edge after estop is sampled high. Ramp-up resumes from OFF on the first sweep after release.
- Reset mid-sweep aborts the sweep. The next sweep starts RAMP_PERIOD cycles after release.
- Back-to-back commands to the same channel: the last accepted command wins.

## Configuration
- MOTOR_RAMP_WATCHDOG_EN defined:
  - A counter clears on every accepted command.
  - On reaching WATCHDOG_CYCLES, all tgt_duty are set to 0, so channels ramp down normally. The counter then holds until the next command.
- Not defined:
  - No watchdog logic exists.
  - Targets persist indefinitely.

## Structure
- `DUTY_CYCLE_SIZE, `MAX_DC and the state encodings (OFF/RAMP/RUN/BRAKE) live in defines.v.
- One sub-module: ramp_tick_gen. It holds the tick counter and slot index and outputs slot_valid/slot_idx.

## Test plan
- Reset check (NUM_MOTORS=4, RAMP_PERIOD=8, RAMP_STEP=8): all outputs 0 during reset; cmd_ready=1 one edge after reset_n rises.
- Ramp-up: cmd motor1 dir=1 on=1 duty=20 → duty_out[1] reads 8, 16, 20 on successive sweeps. on_out[1] is high from the first step; busy[1] is high until 20, then low.
- Reversal: motor1 at 20, dir=1; cmd dir=0 duty=16 → duty reads 12, 4, 0 with dir still 1. The next slot sets dir_out[1]=0 with duty 0, then 8, 16. on_out is 0 at the dir change.
- Clamp and invalid: cmd duty=1023 → target clamps to `MAX_DC. cmd_motor=5 → cmd_err pulses one cycle and no channel changes.
- estop during ramp → on_out=0 and duty_out=0 on the next edge, with cmd_ready=0. After release, a command ramps up from 0.
- With MOTOR_RAMP_WATCHDOG_EN and WATCHDOG_CYCLES=100: motor0 at 16 and no commands → ramps 8, 0 after 100 cycles. Without the macro, it holds 16.
